// File: rtl/difftest_uart_mux.sv
// difftest_uart_mux
//   Shares one simulation UART output among NUM_REQ requesters (per-core
//   uart taps). Each requester writes into a private FIFO. The output is
//   granted one whole line at a time, round-robin, so text from different
//   cores never interleaves mid-line.
//
// Ports
//   clock      sole clock
//   reset      asynchronous reset, active low
//   req_valid  [NUM_REQ]    per-requester character valid
//   req_ch     [8*NUM_REQ]  characters, requester i on bits [8i+7:8i]
//   req_ready  [NUM_REQ]    requester FIFO not full
//   out_valid               character available to the endpoint
//   out_ch     [8]          character to print
//   out_src    [SRC_W]      requester currently (or last) granted
//   out_ready               endpoint accepts the character
//   drop_cnt   [32]         saturating count of rejected valid cycles

// Per-requester lane: FIFO, newline counter, idle timer, eligibility.
module difftest_uart_mux_lane #(
  parameter int          DEPTH   = 16,
  parameter int          FT      = 1024,
  parameter logic [7:0]  NEWLINE = 8'h0A
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       push_valid,
  input  logic [7:0] push_ch,
  input  logic       pop,
  input  logic       granted,
  output logic       ready,
  output logic       empty,
  output logic       last,
  output logic       pushed,
  output logic [7:0] head,
  output logic       eligible
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int TW = $clog2(FT + 1);

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count, nl_cnt;
  logic [TW-1:0] idle_tmr;
  logic          full, popped, push_nl, pop_nl;

  assign full     = (count == CW'(DEPTH));
  assign empty    = (count == '0);
  assign last     = (count == CW'(1));
  assign ready    = !full;
  assign pushed   = push_valid && !full;
  assign popped   = pop && !empty;
  assign head     = mem[rd_ptr];
  assign push_nl  = pushed && (push_ch == NEWLINE);
  assign pop_nl   = popped && (head == NEWLINE);
  assign eligible = (nl_cnt != '0) || full || (!empty && idle_tmr == TW'(FT));

  // Storage carries no reset; occupancy alone defines validity.
  always_ff @(posedge clock) begin
    if (pushed) mem[wr_ptr] <= push_ch;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      nl_cnt   <= '0;
      idle_tmr <= '0;
    end else begin
      if (pushed) wr_ptr <= wr_ptr + AW'(1);
      if (popped) rd_ptr <= rd_ptr + AW'(1);
      count <= count + CW'(pushed) - CW'(popped);
      case ({push_nl, pop_nl})
        2'b10:   nl_cnt <= nl_cnt + CW'(1);
        2'b01:   nl_cnt <= nl_cnt - CW'(1);
        default: nl_cnt <= nl_cnt;
      endcase
      // Timer measures how long a partial line has sat untouched; it is
      // frozen while the lane owns the output.
      if (pushed || empty)
        idle_tmr <= '0;
      else if (!granted && idle_tmr != TW'(FT))
        idle_tmr <= idle_tmr + TW'(1);
    end
  end
endmodule

module difftest_uart_mux #(
  parameter int          NUM_REQ       = 4,
  parameter int          BUF_DEPTH     = 16,
  parameter int          FLUSH_TIMEOUT = 1024,
  parameter logic [7:0]  NEWLINE       = 8'h0A,
  localparam int         SRC_W         = $clog2(NUM_REQ)
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic [NUM_REQ-1:0]   req_valid,
  input  logic [8*NUM_REQ-1:0] req_ch,
  output logic [NUM_REQ-1:0]   req_ready,
  output logic                 out_valid,
  output logic [7:0]           out_ch,
  output logic [SRC_W-1:0]     out_src,
  input  logic                 out_ready,
  output logic [31:0]          drop_cnt
);
  localparam logic [0:0]   IDLE   = 1'b0;
  localparam logic [0:0]   SEND   = 1'b1;
  localparam int           SUMW   = $clog2(NUM_REQ + 1);
  localparam logic [SRC_W:0] NREQ_W = (SRC_W+1)'(NUM_REQ);

  logic [0:0]                state;
  logic [SRC_W-1:0]          rr, src_q, rr_next;
  logic [NUM_REQ-1:0]        ready_v, empty_v, last_v, pushed_v, elig;
  logic [NUM_REQ-1:0][7:0]   head_v;
  logic [7:0]                head_sel;
  logic                      sel_empty, pop, line_end;

  genvar i;
  generate
    for (i = 0; i < NUM_REQ; i++) begin : g_lane
      difftest_uart_mux_lane #(
        .DEPTH   (BUF_DEPTH),
        .FT      (FLUSH_TIMEOUT),
        .NEWLINE (NEWLINE)
      ) u_lane (
        .clock      (clock),
        .reset      (reset),
        .push_valid (req_valid[i]),
        .push_ch    (req_ch[8*i +: 8]),
        .pop        (pop && (src_q == SRC_W'(i))),
        .granted    ((state == SEND) && (src_q == SRC_W'(i))),
        .ready      (ready_v[i]),
        .empty      (empty_v[i]),
        .last       (last_v[i]),
        .pushed     (pushed_v[i]),
        .head       (head_v[i]),
        .eligible   (elig[i])
      );
    end
  endgenerate

  assign req_ready = ready_v;
  assign out_src   = src_q;
  assign head_sel  = head_v[src_q];
  assign sel_empty = empty_v[src_q];
  assign out_valid = (state == SEND) && !sel_empty;
  assign out_ch    = out_valid ? head_sel : 8'h00;
  assign pop       = out_valid && out_ready;
  // A line also ends when the pop drains the FIFO (timeout/full grants
  // carry no newline); a same-cycle push keeps the line open.
  assign line_end  = pop && ((head_sel == NEWLINE) ||
                             (last_v[src_q] && !pushed_v[src_q]));
  assign rr_next   = (src_q == SRC_W'(NUM_REQ - 1)) ? '0 : src_q + SRC_W'(1);

  // Round-robin pick: rotate eligibility so rr sits at bit 0, take the
  // lowest set bit, then rotate the offset back into a requester index.
  logic [2*NUM_REQ-1:0] dbl;
  logic [NUM_REQ-1:0]   rot;
  logic [SRC_W-1:0]     pick_off, pick_idx;
  logic [SRC_W:0]       pick_sum;
  logic                 pick_vld;

  always_comb begin
    dbl      = {elig, elig} >> rr;
    rot      = dbl[NUM_REQ-1:0];
    pick_vld = |rot;
    pick_off = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--)
      if (rot[k]) pick_off = SRC_W'(k);
    pick_sum = {1'b0, rr} + {1'b0, pick_off};
    if (pick_sum >= NREQ_W) pick_sum = pick_sum - NREQ_W;
    pick_idx = pick_sum[SRC_W-1:0];
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      rr    <= '0;
      src_q <= '0;
    end else begin
      case (state)
        IDLE: if (pick_vld) begin
          src_q <= pick_idx;
          state <= SEND;
        end
        default: if (line_end || sel_empty) begin
          state <= IDLE;
          rr    <= rr_next;
        end
      endcase
    end
  end

  // Drop accounting: one per requester per rejected-valid cycle.
  logic [SUMW-1:0] rej_sum;
  logic [32:0]     drop_next;

  always_comb begin
    rej_sum = '0;
    for (int k = 0; k < NUM_REQ; k++)
      rej_sum = rej_sum + SUMW'(req_valid[k] && !ready_v[k]);
    drop_next = {1'b0, drop_cnt} + 33'(rej_sum);
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) drop_cnt <= '0;
    else        drop_cnt <= drop_next[32] ? 32'hFFFF_FFFF : drop_next[31:0];
  end
endmodule

// File: tb/tb_difftest_uart_mux.sv
// Directed bench for difftest_uart_mux (NUM_REQ=4, BUF_DEPTH=16,
// FLUSH_TIMEOUT=8). Inputs change and outputs are sampled 1ns after each
// rising edge.
module tb_difftest_uart_mux;
  logic        clock = 1'b0;
  logic        reset;
  logic [3:0]  req_valid;
  logic [31:0] req_ch;
  logic [3:0]  req_ready;
  logic        out_valid;
  logic [7:0]  out_ch;
  logic [1:0]  out_src;
  logic        out_ready;
  logic [31:0] drop_cnt;

  int checks   = 0;
  int failures = 0;

  difftest_uart_mux #(
    .NUM_REQ(4), .BUF_DEPTH(16), .FLUSH_TIMEOUT(8), .NEWLINE(8'h0A)
  ) dut (
    .clock(clock), .reset(reset), .req_valid(req_valid), .req_ch(req_ch),
    .req_ready(req_ready), .out_valid(out_valid), .out_ch(out_ch),
    .out_src(out_src), .out_ready(out_ready), .drop_cnt(drop_cnt)
  );

  always #5 clock = ~clock;

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic set_ch(input int i, input logic [7:0] c);
    req_ch[8*i +: 8] = c;
  endtask

  task automatic push_str(input int i, input string s);
    for (int k = 0; k < s.len(); k++) begin
      req_valid[i] = 1'b1;
      set_ch(i, s[k]);
      step();
    end
    req_valid[i] = 1'b0;
  endtask

  // Two requesters push equal-length strings in lockstep.
  task automatic push_two(input int a, input string sa, input int b, input string sb);
    for (int k = 0; k < sa.len(); k++) begin
      req_valid[a] = 1'b1; set_ch(a, sa[k]);
      req_valid[b] = 1'b1; set_ch(b, sb[k]);
      step();
    end
    req_valid[a] = 1'b0;
    req_valid[b] = 1'b0;
  endtask

  task automatic expect_char(input string tag, input logic [7:0] c, input logic [1:0] src);
    chk({tag, "_vld"}, 32'(out_valid), 32'd1);
    chk({tag, "_ch"},  32'(out_ch),    32'(c));
    chk({tag, "_src"}, 32'(out_src),   32'(src));
    step();
  endtask

  task automatic expect_idle(input string tag);
    chk({tag, "_idle"}, 32'(out_valid), 32'd0);
    step();
  endtask

  task automatic do_reset();
    reset = 1'b0;
    req_valid = '0;
    step();
    step();
    reset = 1'b1;
  endtask

  int  sent, rx;
  bit  early, push_now;

  initial begin
    reset = 1'b0; req_valid = '0; req_ch = '0; out_ready = 1'b1;
    step(); step();

    // Reset state
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_ch",    32'(out_ch),    32'd0);
    chk("rst_src",   32'(out_src),   32'd0);
    chk("rst_ready", 32'(req_ready), 32'hF);
    chk("rst_drop",  drop_cnt,       32'd0);
    reset = 1'b1;
    step();

    // Single line from req0: one-cycle grant latency after the newline
    push_str(0, "hi\n");
    expect_idle("t1_lat");
    expect_char("t1_h",  8'h68, 2'd0);
    expect_char("t1_i",  8'h69, 2'd0);
    expect_char("t1_nl", 8'h0A, 2'd0);
    expect_idle("t1_end");

    // Two complete lines at once from rr=0: req0 first, bubble, req1
    do_reset();
    step();
    push_two(0, "AB\n", 1, "xy\n");
    expect_idle("t2_lat");
    expect_char("t2_a",  8'h41, 2'd0);
    expect_char("t2_b",  8'h42, 2'd0);
    expect_char("t2_n0", 8'h0A, 2'd0);
    expect_idle("t2_bubble");
    expect_char("t2_x",  8'h78, 2'd1);
    expect_char("t2_y",  8'h79, 2'd1);
    expect_char("t2_n1", 8'h0A, 2'd1);
    expect_idle("t2_end");

    // rr is now 2: req3 must win over req1
    push_two(1, "1\n", 3, "3\n");
    expect_idle("rr_lat");
    expect_char("rr_3",  8'h33, 2'd3);
    expect_char("rr_n3", 8'h0A, 2'd3);
    expect_idle("rr_bubble");
    expect_char("rr_1",  8'h31, 2'd1);
    expect_char("rr_n1", 8'h0A, 2'd1);
    expect_idle("rr_end");

    // Partial line flushed by timeout: grant 9 edges after the last push
    push_str(2, "ab");
    chk("t3_wait0", 32'(out_valid), 32'd0);
    for (int k = 0; k < 8; k++) begin
      step();
      chk("t3_wait", 32'(out_valid), 32'd0);
    end
    step();
    expect_char("t3_a", 8'h61, 2'd2);
    expect_char("t3_b", 8'h62, 2'd2);
    expect_idle("t3_end");

    // 20 chars without newline: granted when full, all delivered in order
    sent = 0; rx = 0; early = 1'b0;
    for (int cyc = 0; cyc < 200; cyc++) begin
      if (out_valid && out_ready) begin
        chk("t4_ch",  32'(out_ch),  32'h40 + 32'(rx));
        chk("t4_src", 32'(out_src), 32'd1);
        rx++;
      end
      if (out_valid && sent < 16) early = 1'b1;
      if (rx == 20) break;
      push_now = req_ready[1] && sent < 20;
      req_valid[1] = push_now;
      set_ch(1, 8'(8'h40 + sent));
      step();
      if (push_now) sent++;
    end
    req_valid[1] = 1'b0;
    chk("t4_count", 32'(rx), 32'd20);
    chk("t4_early", 32'(early), 32'd0);
    chk("t4_drop",  drop_cnt, 32'd0);
    step();
    chk("t4_end_idle", 32'(out_valid), 32'd0);
    step();

    // Back-pressure mid-line
    push_str(0, "pqr\n");
    expect_idle("t5_lat");
    expect_char("t5_p", 8'h70, 2'd0);
    out_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      chk("t5_hold_vld", 32'(out_valid), 32'd1);
      chk("t5_hold_ch",  32'(out_ch),    32'h71);
      chk("t5_hold_src", 32'(out_src),   32'd0);
      step();
    end
    out_ready = 1'b1;
    expect_char("t5_q",  8'h71, 2'd0);
    expect_char("t5_r",  8'h72, 2'd0);
    expect_char("t5_nl", 8'h0A, 2'd0);
    expect_idle("t5_end");

    // Drops on a full FIFO, then async reset clears everything
    out_ready = 1'b0;
    for (int k = 0; k < 16; k++) begin
      req_valid[3] = 1'b1;
      set_ch(3, 8'(8'h50 + k));
      step();
    end
    chk("t6_ready_full", 32'(req_ready), 32'h7);
    step(); step(); step();
    req_valid[3] = 1'b0;
    chk("t6_drop",   drop_cnt,          32'd3);
    chk("t6_grant",  32'(out_valid),    32'd1);
    chk("t6_head",   32'(out_ch),       32'h50);
    chk("t6_src",    32'(out_src),      32'd3);
    reset = 1'b0;
    #1;
    chk("t6_rst_drop",  drop_cnt,          32'd0);
    chk("t6_rst_vld",   32'(out_valid),    32'd0);
    chk("t6_rst_ready", 32'(req_ready),    32'hF);
    chk("t6_rst_src",   32'(out_src),      32'd0);
    chk("t6_rst_ch",    32'(out_ch),       32'd0);
    step();
    reset = 1'b1;
    out_ready = 1'b1;
    step();
    step();
    chk("t6_post_vld",   32'(out_valid), 32'd0);
    chk("t6_post_ready", 32'(req_ready), 32'hF);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
